// File: rtl/oc_pkg.sv
// Shared types and helpers for the operand collector: FSM states, operand/lane counts,
// and the one-hot to bank-index reduction used by both the arbiter and the capture path.
package oc_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} oc_state_e;

    localparam int LANES   = 4;
    localparam int NUM_OPS = 3;

    // Lowest set bit wins, so a malformed (multi-hot) select still maps to a single bank.
    function automatic int bank_index(input logic [31:0] onehot);
        for (int b = 0; b < 32; b++) begin
            if (onehot[b]) return b;
        end
        return 0;
    endfunction

endpackage

// File: rtl/oc_bank_arbiter.sv
// Combinational per-bank read arbiter: picks the lowest-index pending operand on each bank and
// folds in any later pending operand on that bank that wants the same address.
module oc_bank_arbiter
    import oc_pkg::*;
#(
    parameter int TotalNumBank = 8,
    parameter int AddrWidth    = 5
) (
    input  logic [NUM_OPS-1:0]                   pending,
    input  logic [NUM_OPS-1:0][TotalNumBank-1:0] read_en,
    input  logic [NUM_OPS-1:0][AddrWidth-1:0]    read_addr,
    output logic [NUM_OPS-1:0]                   grant,
    output logic [TotalNumBank-1:0]              rf_rd_en,
    output logic [TotalNumBank*AddrWidth-1:0]    rf_rd_addr
);

    localparam int BIW = (TotalNumBank > 1) ? $clog2(TotalNumBank) : 1;

    logic [BIW-1:0] bidx [NUM_OPS];

    always_comb begin
        for (int i = 0; i < NUM_OPS; i++) begin
            bidx[i] = BIW'(bank_index(32'(read_en[i])));
        end
    end

    always_comb begin
        logic found;
        logic lead_ok;
        grant      = '0;
        rf_rd_en   = '0;
        rf_rd_addr = '0;
        found      = 1'b0;
        lead_ok    = 1'b1;
        for (int i = 0; i < NUM_OPS; i++) begin
            found   = 1'b0;
            lead_ok = 1'b1;
            // The first lower-index pending operand on the same bank owns the port this cycle.
            for (int j = 0; j < i; j++) begin
                if (!found && pending[j] && (bidx[j] == bidx[i])) begin
                    found   = 1'b1;
                    lead_ok = (read_addr[j] == read_addr[i]);
                end
            end
            grant[i] = pending[i] && lead_ok;
            if (grant[i]) begin
                rf_rd_en[bidx[i]]                          = 1'b1;
                rf_rd_addr[bidx[i]*AddrWidth +: AddrWidth] = read_addr[i];
            end
        end
    end

endmodule

// File: rtl/operand_collector.sv
// Operand collector: latches one decoded instruction, reads up to three operands from the banked
// register file (serialising bank conflicts), then holds the collected operands for the RF->EX stage.
module operand_collector
    import oc_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int TotalNumBank = 8,
    parameter int AddrWidth    = 5,
    parameter int SbWidth      = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sclr,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [TotalNumBank-1:0]              readEn1_d,
    input  logic [TotalNumBank-1:0]              readEn2_d,
    input  logic [TotalNumBank-1:0]              readEn3_d,
    input  logic [AddrWidth-1:0]                 readAddr1_d,
    input  logic [AddrWidth-1:0]                 readAddr2_d,
    input  logic [AddrWidth-1:0]                 readAddr3_d,
    input  logic [SbWidth-1:0]                   sb_d,
    output logic [TotalNumBank-1:0]              rf_rd_en,
    output logic [TotalNumBank*AddrWidth-1:0]    rf_rd_addr,
    input  logic [TotalNumBank*LANES*DataWidth-1:0] rf_rd_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES*DataWidth-1:0]           readData1,
    output logic [LANES*DataWidth-1:0]           readData2,
    output logic [LANES*DataWidth-1:0]           readData3,
    output logic [TotalNumBank-1:0]              readEn1_r,
    output logic [TotalNumBank-1:0]              readEn2_r,
    output logic [TotalNumBank-1:0]              readEn3_r,
    output logic [AddrWidth-1:0]                 readAddr1_r,
    output logic [AddrWidth-1:0]                 readAddr2_r,
    output logic [AddrWidth-1:0]                 readAddr3_r,
    output logic [SbWidth-1:0]                   sb_r,
    output logic                                 err_bank
);

    localparam int OPW = LANES * DataWidth;
    localparam int BIW = (TotalNumBank > 1) ? $clog2(TotalNumBank) : 1;

    oc_state_e state, state_nx;

    logic [NUM_OPS-1:0]                   pending, inflight, grant, arb_pending, new_pending;
    logic [NUM_OPS-1:0][TotalNumBank-1:0] en_d, en_r;
    logic [NUM_OPS-1:0][AddrWidth-1:0]    addr_d, addr_r;
    logic [OPW-1:0]                       data_r [NUM_OPS];
    logic [BIW-1:0]                       bidx   [NUM_OPS];
    logic                                 accept, bad_en;

    assign en_d   = {readEn3_d, readEn2_d, readEn1_d};
    assign addr_d = {readAddr3_d, readAddr2_d, readAddr1_d};

    assign accept      = (state == IDLE) && in_valid;
    assign arb_pending = (state == ISSUE) ? pending : '0;

    always_comb begin
        bad_en = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            new_pending[i] = |en_d[i];
            bidx[i]        = BIW'(bank_index(32'(en_r[i])));
            if ((en_d[i] & (en_d[i] - TotalNumBank'(1))) != '0) bad_en = 1'b1;
        end
    end

    oc_bank_arbiter #(
        .TotalNumBank (TotalNumBank),
        .AddrWidth    (AddrWidth)
    ) u_arb (
        .pending    (arb_pending),
        .read_en    (en_r),
        .read_addr  (addr_r),
        .grant      (grant),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = (|new_pending) ? ISSUE : HOLD;
            ISSUE:   if ((pending & ~grant) == '0) state_nx = WAIT;
            WAIT:    state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            inflight <= '0;
            en_r     <= '0;
            addr_r   <= '0;
            sb_r     <= '0;
            err_bank <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) data_r[i] <= '0;
        end else if (sclr) begin
            state    <= IDLE;
            pending  <= '0;
            inflight <= '0;
            en_r     <= '0;
            addr_r   <= '0;
            sb_r     <= '0;
            err_bank <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) data_r[i] <= '0;
        end else begin
            state    <= state_nx;
            err_bank <= accept && bad_en;
            inflight <= grant;
            if (accept) begin
                en_r    <= en_d;
                addr_r  <= addr_d;
                sb_r    <= sb_d;
                pending <= new_pending;
                for (int i = 0; i < NUM_OPS; i++) data_r[i] <= '0;
            end else begin
                pending <= pending & ~grant;
                // Read data returns one cycle after the strobe, i.e. while the operand is inflight.
                for (int i = 0; i < NUM_OPS; i++) begin
                    if (inflight[i]) data_r[i] <= rf_rd_data[bidx[i]*OPW +: OPW];
                end
            end
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == HOLD);
    assign readData1   = data_r[0];
    assign readData2   = data_r[1];
    assign readData3   = data_r[2];
    assign readEn1_r   = en_r[0];
    assign readEn2_r   = en_r[1];
    assign readEn3_r   = en_r[2];
    assign readAddr1_r = addr_r[0];
    assign readAddr2_r = addr_r[1];
    assign readAddr3_r = addr_r[2];

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector with a one-cycle-latency banked register file model.
module tb_operand_collector;

    localparam int DW  = 32;
    localparam int NB  = 8;
    localparam int AW  = 5;
    localparam int SBW = 64;
    localparam int OPW = 4 * DW;

    logic            clk = 1'b0;
    logic            rst, sclr, in_valid, in_ready, out_valid, out_ready, err_bank;
    logic [NB-1:0]   en1, en2, en3, en1_r, en2_r, en3_r, rf_rd_en;
    logic [AW-1:0]   a1, a2, a3, a1_r, a2_r, a3_r;
    logic [SBW-1:0]  sb, sb_r;
    logic [NB*AW-1:0]  rf_rd_addr;
    logic [NB*OPW-1:0] rf_q = '0;
    logic [OPW-1:0]  rd1, rd2, rd3, hold_rd1;
    logic [NB-1:0]   en_log   [0:15];
    logic [NB*AW-1:0] addr_log [0:15];
    int checks = 0;
    int failures = 0;
    int lat, issues;

    always #5 clk = ~clk;

    operand_collector #(.DataWidth(DW), .TotalNumBank(NB), .AddrWidth(AW), .SbWidth(SBW)) dut (
        .clk(clk), .rst(rst), .sclr(sclr), .in_valid(in_valid), .in_ready(in_ready),
        .readEn1_d(en1), .readEn2_d(en2), .readEn3_d(en3),
        .readAddr1_d(a1), .readAddr2_d(a2), .readAddr3_d(a3), .sb_d(sb),
        .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .readData1(rd1), .readData2(rd2), .readData3(rd3),
        .readEn1_r(en1_r), .readEn2_r(en2_r), .readEn3_r(en3_r),
        .readAddr1_r(a1_r), .readAddr2_r(a2_r), .readAddr3_r(a3_r),
        .sb_r(sb_r), .err_bank(err_bank)
    );

    function automatic logic [OPW-1:0] rf_val(input int b, input int a);
        logic [OPW-1:0] v;
        for (int l = 0; l < 4; l++) v[l*DW +: DW] = {8'(b), 8'(a), 8'(l), 8'hA5};
        return v;
    endfunction

    // Register file: data for a strobed bank appears on the bus the following cycle.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (rf_rd_en[b]) rf_q[b*OPW +: OPW] <= rf_val(b, int'(rf_rd_addr[b*AW +: AW]));
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NB-1:0] e1, input logic [AW-1:0] d1,
                        input logic [NB-1:0] e2, input logic [AW-1:0] d2,
                        input logic [NB-1:0] e3, input logic [AW-1:0] d3,
                        input logic [SBW-1:0] s);
        en1 = e1; a1 = d1; en2 = e2; a2 = d2; en3 = e3; a3 = d3; sb = s;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    // Called in the first cycle after the accepting edge.
    task automatic run_to_valid(output int l, output int n);
        l = 1;
        n = 0;
        en_log[1] = rf_rd_en; addr_log[1] = rf_rd_addr;
        if (rf_rd_en != '0) n++;
        while (!out_valid && l < 12) begin
            tick;
            l++;
            en_log[l] = rf_rd_en; addr_log[l] = rf_rd_addr;
            if (rf_rd_en != '0) n++;
        end
        check_eq("out_valid_reached", out_valid, 1);
    endtask

    initial begin
        rst = 1'b1; sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        en1 = '0; en2 = '0; en3 = '0; a1 = '0; a2 = '0; a3 = '0; sb = '0;
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_rd_en", rf_rd_en, 0);
        check_eq("rst_err", err_bank, 0);
        check_eq("rst_rd1", rd1, 0);
        check_eq("rst_sb", sb_r, 0);
        tick; tick;
        rst = 1'b0;
        tick;

        // 1: three distinct banks, no conflict
        send(8'h01, 5'd3, 8'h02, 5'd4, 8'h04, 5'd5, 64'h1111_2222_3333_4444);
        run_to_valid(lat, issues);
        check_eq("t1_lat", lat, 3);
        check_eq("t1_issues", issues, 1);
        check_eq("t1_en", en_log[1], 8'h07);
        check_eq("t1_addr0", addr_log[1][0 +: AW], 3);
        check_eq("t1_addr1", addr_log[1][AW +: AW], 4);
        check_eq("t1_addr2", addr_log[1][2*AW +: AW], 5);
        check_eq("t1_rd1", rd1, rf_val(0, 3));
        check_eq("t1_rd2", rd2, rf_val(1, 4));
        check_eq("t1_rd3", rd3, rf_val(2, 5));
        check_eq("t1_sb", sb_r, 64'h1111_2222_3333_4444);
        check_eq("t1_en2_r", en2_r, 8'h02);
        check_eq("t1_a3_r", a3_r, 5);
        tick;
        check_eq("t1_idle", in_ready, 1);

        // 2: op1/op3 conflict on bank 4, different addresses
        send(8'h10, 5'd2, 8'h00, 5'd0, 8'h10, 5'd7, 64'h2);
        run_to_valid(lat, issues);
        check_eq("t2_lat", lat, 4);
        check_eq("t2_issues", issues, 2);
        check_eq("t2_en_c1", en_log[1], 8'h10);
        check_eq("t2_addr_c1", addr_log[1][4*AW +: AW], 2);
        check_eq("t2_en_c2", en_log[2], 8'h10);
        check_eq("t2_addr_c2", addr_log[2][4*AW +: AW], 7);
        check_eq("t2_rd1", rd1, rf_val(4, 2));
        check_eq("t2_rd2", rd2, 0);
        check_eq("t2_rd3", rd3, rf_val(4, 7));
        tick;

        // 3: op1/op2 same bank and address merge into one read
        send(8'h20, 5'd9, 8'h20, 5'd9, 8'h00, 5'd0, 64'h3);
        run_to_valid(lat, issues);
        check_eq("t3_lat", lat, 3);
        check_eq("t3_issues", issues, 1);
        check_eq("t3_rd1", rd1, rf_val(5, 9));
        check_eq("t3_rd2", rd2, rf_val(5, 9));
        tick;

        // 4: no operands at all
        send(8'h00, 5'd1, 8'h00, 5'd2, 8'h00, 5'd3, 64'h4);
        run_to_valid(lat, issues);
        check_eq("t4_lat", lat, 1);
        check_eq("t4_issues", issues, 0);
        check_eq("t4_rd1", rd1, 0);
        check_eq("t4_rd3", rd3, 0);
        tick;

        // 5: back-pressure in HOLD with a new instruction waiting
        out_ready = 1'b0;
        send(8'h01, 5'd1, 8'h08, 5'd2, 8'h80, 5'd31, 64'h5555);
        run_to_valid(lat, issues);
        check_eq("t5_lat", lat, 3);
        hold_rd1 = rd1;
        check_eq("t5_rd3", rd3, rf_val(7, 31));
        en1 = 8'h04; a1 = 5'd10; en2 = '0; en3 = '0; sb = 64'h6666;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check_eq("t5_hold_valid", out_valid, 1);
            check_eq("t5_hold_ready", in_ready, 0);
            check_eq("t5_hold_rd1", rd1, hold_rd1);
            check_eq("t5_hold_sb", sb_r, 64'h5555);
        end
        out_ready = 1'b1;
        tick;
        check_eq("t5_post_hs_ready", in_ready, 1);
        check_eq("t5_post_hs_valid", out_valid, 0);
        tick;
        in_valid = 1'b0;
        check_eq("t5_accepted", in_ready, 0);
        run_to_valid(lat, issues);
        check_eq("t5b_lat", lat, 3);
        check_eq("t5b_rd1", rd1, rf_val(2, 10));
        check_eq("t5b_sb", sb_r, 64'h6666);
        tick;

        // 6a: sclr in the middle of a 3-way conflict
        send(8'h40, 5'd1, 8'h40, 5'd2, 8'h40, 5'd3, 64'h7);
        check_eq("t6_issue_c1", rf_rd_en, 8'h40);
        tick;
        sclr = 1'b1;
        tick;
        sclr = 1'b0;
        check_eq("t6_sclr_ready", in_ready, 1);
        check_eq("t6_sclr_valid", out_valid, 0);
        check_eq("t6_sclr_rd_en", rf_rd_en, 0);
        check_eq("t6_sclr_rd1", rd1, 0);
        tick; tick;
        check_eq("t6_stale_rd1", rd1, 0);
        check_eq("t6_stale_valid", out_valid, 0);
        sclr = 1'b1; in_valid = 1'b1; en1 = 8'h01;
        tick;
        sclr = 1'b0; in_valid = 1'b0;
        check_eq("t6_sclr_beats_valid", in_ready, 1);

        // 6b: multi-hot select uses the lowest bank and flags err_bank
        send(8'h06, 5'd8, 8'h01, 5'd0, 8'h00, 5'd0, 64'h8);
        check_eq("t6_err_pulse", err_bank, 1);
        check_eq("t6_err_rd_en", rf_rd_en, 8'h03);
        run_to_valid(lat, issues);
        check_eq("t6_err_clear", err_bank, 0);
        check_eq("t6_lat", lat, 3);
        check_eq("t6_rd1", rd1, rf_val(1, 8));
        check_eq("t6_rd2", rd2, rf_val(0, 0));
        check_eq("t6_en1_r", en1_r, 8'h06);
        tick;

        // 6c: asynchronous reset in the middle of a 3-way conflict
        send(8'h40, 5'd4, 8'h40, 5'd5, 8'h40, 5'd6, 64'h9);
        tick;
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_ready", in_ready, 1);
        check_eq("t6_rst_valid", out_valid, 0);
        check_eq("t6_rst_rd_en", rf_rd_en, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick;
        check_eq("t6_rst_rd1", rd1, 0);
        send(8'h80, 5'd12, 8'h08, 5'd13, 8'h01, 5'd14, 64'hA);
        run_to_valid(lat, issues);
        check_eq("t6_after_rst_lat", lat, 3);
        check_eq("t6_after_rst_rd1", rd1, rf_val(7, 12));
        check_eq("t6_after_rst_rd2", rd2, rf_val(3, 13));
        check_eq("t6_after_rst_rd3", rd3, rf_val(0, 14));
        check_eq("t6_after_rst_a2_r", a2_r, 13);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
